// File: rtl/multdiv_ula.sv
// multdiv_ula -- iterative multiply/divide unit holding the HI/LO registers.
//
// Runs MULT/MULTU/DIV/DIVU one iteration per clock edge. Signed operations
// work on operand magnitudes; the result signs are fixed at the end.
//
// Handshake: a request is accepted on the rising edge where iniciar=1 and the
// unit is idle (ocupado=0). Operands are latched on that edge and ocupado
// rises. Requests made while ocupado=1 are dropped. Exactly WIDTH+1 edges
// after acceptance (one edge for divide-by-zero), pronto pulses for a single
// cycle, ocupado falls and hi/lo hold the result. A new request may be raised
// in the pronto cycle and is accepted on the following edge.
//
// Ports:
//   clock     rising-edge system clock
//   reset     asynchronous active-low reset
//   iniciar   start request
//   operacao  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   entradaA  multiplicand / dividend
//   entradaB  multiplier / divisor
//   ocupado   operation in progress
//   pronto    one-cycle completion pulse
//   hi, lo    product high/low half, or remainder/quotient
//   divZero   last divide had a zero divisor; cleared by the next accept
//   estado    current FSM state (0 OCIOSO, 1 CALCULA, 2 FINALIZA)
module multdiv_ula #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic [1:0]       operacao,
  input  logic [WIDTH-1:0] entradaA,
  input  logic [WIDTH-1:0] entradaB,
  output logic             ocupado,
  output logic             pronto,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero,
  output logic [1:0]       estado
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CALCULA  = 2'd1,
    FINALIZA = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;
  // Upper half: partial product / partial remainder.
  // Lower half: remaining multiplier bits / dividend bits becoming quotient.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;       // multiplicand or divisor magnitude
  logic               op_div;
  logic               dz_pend;     // divide by zero detected at accept
  logic               neg_main;    // product sign, or quotient sign
  logic               neg_rem;     // remainder sign (sign of dividend)

  logic               accept;
  logic               op_signed;
  logic               b_zero;
  logic               last_iter;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign ocupado = (state != OCIOSO);
  assign estado  = state;

  // Operand conditioning at the accept edge
  always_comb begin
    accept    = (state == OCIOSO) && iniciar;
    op_signed = ~operacao[0];
    b_zero    = (entradaB == '0);
    a_neg     = op_signed & entradaA[WIDTH-1];
    b_neg     = op_signed & entradaB[WIDTH-1];
    a_mag     = a_neg ? -entradaA : entradaA;
    b_mag     = b_neg ? -entradaB : entradaB;
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // One iteration of each algorithm
  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right,
    // keeping the carry out of the addition.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // try subtracting the divisor. A negative difference (MSB set) means the
    // subtraction is undone and the quotient bit is 0.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (div_diff[WIDTH])
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction applied when the results are written
  always_comb begin
    prod = neg_main ? -acc : acc;
    if (op_div) begin
      fin_lo = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fin_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= OCIOSO;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      OCIOSO: begin
        if (accept)
          state_next = (operacao[1] && b_zero) ? FINALIZA : CALCULA;
      end
      CALCULA: begin
        if (last_iter) state_next = FINALIZA;
      end
      FINALIZA: state_next = OCIOSO;
      default:  state_next = OCIOSO;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      op_div   <= 1'b0;
      dz_pend  <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      pronto   <= 1'b0;
      divZero  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      pronto <= 1'b0;
      case (state)
        OCIOSO: begin
          if (accept) begin
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, a_mag};
            mcand    <= b_mag;
            op_div   <= operacao[1];
            dz_pend  <= operacao[1] & b_zero;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            divZero  <= 1'b0;
          end
        end
        CALCULA: begin
          cnt <= cnt + 1'b1;
          acc <= op_div ? div_next : mul_next;
        end
        FINALIZA: begin
          pronto <= 1'b1;
          if (dz_pend) begin
            divZero <= 1'b1;
          end else begin
            hi <= fin_hi;
            lo <= fin_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multdiv_ula.md
Name: multdiv_ula

Overview:
- Iterative multiply/divide unit for the MIPS pipeline; the multi-cycle counterpart to the single-cycle ALU.
- Executes MULT/MULTU/DIV/DIVU and holds the HI/LO registers that MFHI/MFLO read.
- Driven by the EX stage over an iniciar/ocupado/pronto handshake. Hazard logic stalls on ocupado.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- iniciar  input  1  start request; accepted only while ocupado=0.
- operacao  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- entradaA  input  WIDTH  multiplicand / dividend.
- entradaB  input  WIDTH  multiplier / divisor.
- ocupado  output  1  high while an operation is in progress.
- pronto  output  1  one-cycle pulse when hi/lo are updated or when divide-by-zero is reported.
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.
- divZero  output  1  set with pronto when a DIV/DIVU has divisor 0; held until the next accepted start.

Behaviour:
- Reset (reset=0, any time, including mid-operation):
  - Asynchronously forces OCIOSO.
  - ocupado=0, pronto=0, divZero=0, hi=0, lo=0.
  - Internal counter and accumulators are cleared.
- States:
  - OCIOSO → CALCULA on iniciar=1 with a nonzero divisor (or any multiply).
  - OCIOSO → FINALIZA on iniciar=1 for DIV/DIVU with entradaB=0.
  - CALCULA → FINALIZA when the counter reaches WIDTH iterations.
  - FINALIZA → OCIOSO unconditionally.
- Accept edge (E0):
  - Operands and operacao are latched; later input changes are ignored.
  - divZero is cleared and ocupado=1 from E0 onward.
  - For signed ops, magnitudes and result signs are computed at latch.
- CALCULA: one iteration per edge, E1..E_WIDTH.
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes.
- FINALIZA edge (E_WIDTH+1): applies sign correction, writes hi/lo, pronto=1 for exactly that cycle, ocupado=0.
- Latency: pronto is visible WIDTH+1 edges after accept (33 for WIDTH=32).
- Signed rules:
  - Product = two's-complement 2*WIDTH result.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- -2^(WIDTH-1) / -1: lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero:
  - Path is OCIOSO → FINALIZA at E0; FINALIZA at E1 gives pronto=1, divZero=1, ocupado=0.
  - hi/lo keep their previous values.
- iniciar while ocupado=1 is ignored; it is neither queued nor does it disturb the operation.
- Back-to-back: iniciar=1 in the pronto cycle is accepted on the next edge.
- hi/lo change only on a FINALIZA edge (or reset). They are stable otherwise and readable at any time.

Test Plan:
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF → after 33 edges, one pronto pulse; hi=0xFFFFFFFE, lo=0x00000001; ocupado high for exactly 33 cycles.
- MULT, A=-3 (0xFFFFFFFD), B=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT, A=B=0x80000000 → hi=0x40000000, lo=0.
- DIV, A=-7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, A=100, B=7 → lo=14, hi=2. DIV, A=0x80000000, B=-1 → lo=0x80000000, hi=0.
- Preload hi/lo via MULTU 5*6, then DIVU 100/0 → pronto and divZero on the edge after accept; hi=0, lo=30 unchanged. A following DIVU 9/3 clears divZero.
- Start MULTU 3*4, pulse iniciar with different operands at cycle 10, and change entradaA mid-op → result still hi=0, lo=12, with a single pronto pulse. Issue a new start in the pronto cycle → accepted back-to-back.
- Start DIVU 1000/3, assert reset=0 asynchronously at cycle 15 → ocupado, pronto, hi, lo and divZero are 0 immediately. After release, MULTU 2*3 completes normally with lo=6.
